// File: rtl/bali_pkg.sv
// Shared definitions for the Bali execute stage.
//   alu_op_e  : ALU operation codes produced by the decoder and consumed by alu.
//   OP_*      : JVM opcode constants the decoder recognises.
package bali_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_MUL  = 4'h2,
    ALU_DIV  = 4'h3,
    ALU_REM  = 4'h4,
    ALU_NEG  = 4'h5,
    ALU_SHL  = 4'h6,
    ALU_SHR  = 4'h7,
    ALU_USHR = 4'h8,
    ALU_AND  = 4'h9,
    ALU_OR   = 4'hA,
    ALU_XOR  = 4'hB
  } alu_op_e;

  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_ICONST_M1 = 8'h02;
  localparam logic [7:0] OP_ICONST_5  = 8'h08;
  localparam logic [7:0] OP_BIPUSH    = 8'h10;
  localparam logic [7:0] OP_SIPUSH    = 8'h11;
  localparam logic [7:0] OP_IADD      = 8'h60;
  localparam logic [7:0] OP_ISUB      = 8'h64;
  localparam logic [7:0] OP_IMUL      = 8'h68;
  localparam logic [7:0] OP_IDIV      = 8'h6C;
  localparam logic [7:0] OP_IREM      = 8'h70;
  localparam logic [7:0] OP_INEG      = 8'h74;
  localparam logic [7:0] OP_ISHL      = 8'h78;
  localparam logic [7:0] OP_ISHR      = 8'h7A;
  localparam logic [7:0] OP_IUSHR     = 8'h7C;
  localparam logic [7:0] OP_IAND      = 8'h7E;
  localparam logic [7:0] OP_IOR       = 8'h80;
  localparam logic [7:0] OP_IXOR      = 8'h82;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit JVM integer ALU. Computes operand_a op operand_b.
//   operand_a  in  32 : value1 (deeper stack entry)
//   operand_b  in  32 : value2 (top of stack); shift amount uses bits [4:0]
//   op_select  in   4 : alu_op_e code; unused codes C..F give 0
//   result_lo  out 32 : result, low word of the product for mul
//   result_hi  out 32 : high word of the signed product for mul, else 0
//   div_zero   out  1 : div/rem with operand_b == 0
module alu
  import bali_pkg::*;
(
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [3:0]  op_select,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        div_zero
);

  // Truncating signed division. The single overflow case (MIN / -1) wraps
  // back to MIN instead of relying on the simulator's or synthesiser's
  // handling of an unrepresentable quotient.
  function automatic logic [31:0] sdiv_trunc(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    if (b == 0)
      return 32'd0;
    else if (a == 32'sh80000000 && b == -32'sd1)
      return 32'h80000000;
    else
      return 32'(a / b);
  endfunction

  // Remainder whose sign follows the dividend; MIN % -1 is 0.
  function automatic logic [31:0] srem_trunc(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    if (b == 0 || (a == 32'sh80000000 && b == -32'sd1))
      return 32'd0;
    else
      return 32'(a % b);
  endfunction

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic        [63:0] prod;

  assign a_s = signed'(operand_a);
  assign b_s = signed'(operand_b);
  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod = {{32{operand_a[31]}}, operand_a} * {{32{operand_b[31]}}, operand_b};

  always_comb begin
    result_lo = 32'd0;
    result_hi = 32'd0;
    div_zero  = 1'b0;
    case (op_select)
      ALU_ADD:  result_lo = operand_a + operand_b;
      ALU_SUB:  result_lo = operand_a - operand_b;
      ALU_MUL: begin
        result_lo = prod[31:0];
        result_hi = prod[63:32];
      end
      ALU_DIV: begin
        result_lo = sdiv_trunc(a_s, b_s);
        div_zero  = (operand_b == 32'd0);
      end
      ALU_REM: begin
        result_lo = srem_trunc(a_s, b_s);
        div_zero  = (operand_b == 32'd0);
      end
      ALU_NEG:  result_lo = 32'd0 - operand_a;
      ALU_SHL:  result_lo = operand_a << operand_b[4:0];
      ALU_SHR:  result_lo = 32'(a_s >>> operand_b[4:0]);
      ALU_USHR: result_lo = operand_a >> operand_b[4:0];
      ALU_AND:  result_lo = operand_a & operand_b;
      ALU_OR:   result_lo = operand_a | operand_b;
      ALU_XOR:  result_lo = operand_a ^ operand_b;
      default: ;
    endcase
  end

endmodule

// File: rtl/jvm_decode_alu.sv
// Execute stage of the Bali stack processor: combinational JVM bytecode
// decoder plus a registered 32-bit integer ALU.
//   clk, rst (sync, active-high)
//   op_code    in   8 : current opcode (0x00 = nop)
//   exec_start in   1 : pulse; compute with operand_a/operand_b and op_code
//   operand_a  in  32 : value1 (second pop)
//   operand_b  in  32 : value2 (first pop)
//   aluop, isaluop, argc, stackargs, stackwb, constpush, constval : decode (comb)
//   result_lo, result_hi, div_zero : registered results, held until next start
//   done       out  1 : high the cycle after each exec_start
module jvm_decode_alu
  import bali_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  op_code,
  input  logic        exec_start,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [3:0]  aluop,
  output logic        isaluop,
  output logic [1:0]  argc,
  output logic [1:0]  stackargs,
  output logic        stackwb,
  output logic        constpush,
  output logic [31:0] constval,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        div_zero,
  output logic        done
);

  alu_op_e     alu_op;
  logic [31:0] alu_lo;
  logic [31:0] alu_hi;
  logic        alu_dz;

  always_comb begin
    alu_op    = ALU_ADD;
    isaluop   = 1'b0;
    argc      = 2'd0;
    stackargs = 2'd0;
    stackwb   = 1'b0;
    constpush = 1'b0;
    constval  = 32'd0;
    case (op_code) inside
      [OP_ICONST_M1:OP_ICONST_5]: begin
        constpush = 1'b1;
        stackwb   = 1'b1;
        // opcode 0x02..0x08 maps to -1..5; the 32-bit subtraction wraps to sign-extend.
        constval  = {24'd0, op_code} - 32'd3;
      end
      OP_BIPUSH: begin
        argc    = 2'd1;
        stackwb = 1'b1;
      end
      OP_SIPUSH: begin
        argc    = 2'd2;
        stackwb = 1'b1;
      end
      OP_IADD:  alu_op = ALU_ADD;
      OP_ISUB:  alu_op = ALU_SUB;
      OP_IMUL:  alu_op = ALU_MUL;
      OP_IDIV:  alu_op = ALU_DIV;
      OP_IREM:  alu_op = ALU_REM;
      OP_INEG:  alu_op = ALU_NEG;
      OP_ISHL:  alu_op = ALU_SHL;
      OP_ISHR:  alu_op = ALU_SHR;
      OP_IUSHR: alu_op = ALU_USHR;
      OP_IAND:  alu_op = ALU_AND;
      OP_IOR:   alu_op = ALU_OR;
      OP_IXOR:  alu_op = ALU_XOR;
      default: ;
    endcase

    case (op_code)
      OP_IADD, OP_ISUB, OP_IMUL, OP_IDIV, OP_IREM, OP_ISHL, OP_ISHR,
      OP_IUSHR, OP_IAND, OP_IOR, OP_IXOR: begin
        isaluop   = 1'b1;
        stackwb   = 1'b1;
        stackargs = 2'd2;
      end
      OP_INEG: begin
        isaluop   = 1'b1;
        stackwb   = 1'b1;
        stackargs = 2'd1;
      end
      default: ;
    endcase
  end

  assign aluop = alu_op;

  alu u_alu (
    .operand_a (operand_a),
    .operand_b (operand_b),
    .op_select (alu_op),
    .result_lo (alu_lo),
    .result_hi (alu_hi),
    .div_zero  (alu_dz)
  );

  // Stage boundary: ALU outputs captured on exec_start, visible the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_lo <= 32'd0;
      result_hi <= 32'd0;
      div_zero  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= exec_start;
      if (exec_start) begin
        // Non-ALU opcodes still complete, with a zero result.
        result_lo <= isaluop ? alu_lo : 32'd0;
        result_hi <= isaluop ? alu_hi : 32'd0;
        div_zero  <= isaluop ? alu_dz : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jvm_decode_alu.sv
module tb_jvm_decode_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  op_code;
  logic        exec_start;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  aluop;
  logic        isaluop;
  logic [1:0]  argc;
  logic [1:0]  stackargs;
  logic        stackwb;
  logic        constpush;
  logic [31:0] constval;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        div_zero;
  logic        done;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  jvm_decode_alu dut (
    .clk        (clk),
    .rst        (rst),
    .op_code    (op_code),
    .exec_start (exec_start),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .aluop      (aluop),
    .isaluop    (isaluop),
    .argc       (argc),
    .stackargs  (stackargs),
    .stackwb    (stackwb),
    .constpush  (constpush),
    .constval   (constval),
    .result_lo  (result_lo),
    .result_hi  (result_hi),
    .div_zero   (div_zero),
    .done       (done)
  );

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  e_aluop;
    logic        e_isalu;
    logic [1:0]  e_sargs;
    logic [1:0]  e_argc;
    logic        e_swb;
    logic        e_cpush;
    logic [31:0] e_cval;
    logic [31:0] e_lo;
    logic [31:0] e_hi;
    logic        e_dz;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    op_code    = v.op;
    operand_a  = v.a;
    operand_b  = v.b;
    exec_start = 1'b1;
    #1;
    chk($sformatf("v%0d aluop", i), 32'(aluop), 32'(v.e_aluop));
    chk($sformatf("v%0d isaluop", i), 32'(isaluop), 32'(v.e_isalu));
    chk($sformatf("v%0d stackargs", i), 32'(stackargs), 32'(v.e_sargs));
    chk($sformatf("v%0d argc", i), 32'(argc), 32'(v.e_argc));
    chk($sformatf("v%0d stackwb", i), 32'(stackwb), 32'(v.e_swb));
    chk($sformatf("v%0d constpush", i), 32'(constpush), 32'(v.e_cpush));
    chk($sformatf("v%0d constval", i), constval, v.e_cval);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d done", i), 32'(done), 32'd1);
    chk($sformatf("v%0d result_lo", i), result_lo, v.e_lo);
    chk($sformatf("v%0d result_hi", i), result_hi, v.e_hi);
    chk($sformatf("v%0d div_zero", i), 32'(div_zero), 32'(v.e_dz));
    @(negedge clk);
    exec_start = 1'b0;
    operand_a  = 32'hDEADBEEF;
    operand_b  = 32'h12345678;
    @(posedge clk);
    #1;
    chk($sformatf("v%0d done drop", i), 32'(done), 32'd0);
    chk($sformatf("v%0d result hold", i), result_lo, v.e_lo);
  endtask

  initial begin
    //          op     a             b             aop  alu sa  ac  wb  cp  cval          lo            hi            dz
    vecs.push_back('{8'h02, 32'd0,        32'd0,        4'h0, 0, 0, 0, 1, 1, 32'hFFFFFFFF, 32'd0,        32'd0,        0});
    vecs.push_back('{8'h08, 32'd0,        32'd0,        4'h0, 0, 0, 0, 1, 1, 32'd5,        32'd0,        32'd0,        0});
    vecs.push_back('{8'h10, 32'd0,        32'd0,        4'h0, 0, 0, 1, 1, 0, 32'd0,        32'd0,        32'd0,        0});
    vecs.push_back('{8'h11, 32'd0,        32'd0,        4'h0, 0, 0, 2, 1, 0, 32'd0,        32'd0,        32'd0,        0});
    vecs.push_back('{8'h60, 32'd7,        32'd5,        4'h0, 1, 2, 0, 1, 0, 32'd0,        32'd12,       32'd0,        0});
    vecs.push_back('{8'h60, 32'h7FFFFFFF, 32'd1,        4'h0, 1, 2, 0, 1, 0, 32'd0,        32'h80000000, 32'd0,        0});
    vecs.push_back('{8'h64, 32'd3,        32'd10,       4'h1, 1, 2, 0, 1, 0, 32'd0,        32'hFFFFFFF9, 32'd0,        0});
    vecs.push_back('{8'h68, 32'h10000,    32'h10000,    4'h2, 1, 2, 0, 1, 0, 32'd0,        32'd0,        32'd1,        0});
    vecs.push_back('{8'h68, 32'hFFFFFFFE, 32'd3,        4'h2, 1, 2, 0, 1, 0, 32'd0,        32'hFFFFFFFA, 32'hFFFFFFFF, 0});
    vecs.push_back('{8'h6C, 32'hFFFFFFF9, 32'd2,        4'h3, 1, 2, 0, 1, 0, 32'd0,        32'hFFFFFFFD, 32'd0,        0});
    vecs.push_back('{8'h70, 32'hFFFFFFF9, 32'd2,        4'h4, 1, 2, 0, 1, 0, 32'd0,        32'hFFFFFFFF, 32'd0,        0});
    vecs.push_back('{8'h6C, 32'd5,        32'd0,        4'h3, 1, 2, 0, 1, 0, 32'd0,        32'd0,        32'd0,        1});
    vecs.push_back('{8'h70, 32'd5,        32'd0,        4'h4, 1, 2, 0, 1, 0, 32'd0,        32'd0,        32'd0,        1});
    vecs.push_back('{8'h6C, 32'h80000000, 32'hFFFFFFFF, 4'h3, 1, 2, 0, 1, 0, 32'd0,        32'h80000000, 32'd0,        0});
    vecs.push_back('{8'h70, 32'h80000000, 32'hFFFFFFFF, 4'h4, 1, 2, 0, 1, 0, 32'd0,        32'd0,        32'd0,        0});
    vecs.push_back('{8'h74, 32'd5,        32'd123,      4'h5, 1, 1, 0, 1, 0, 32'd0,        32'hFFFFFFFB, 32'd0,        0});
    vecs.push_back('{8'h78, 32'd1,        32'd36,       4'h6, 1, 2, 0, 1, 0, 32'd0,        32'h10,       32'd0,        0});
    vecs.push_back('{8'h7A, 32'h80000000, 32'd33,       4'h7, 1, 2, 0, 1, 0, 32'd0,        32'hC0000000, 32'd0,        0});
    vecs.push_back('{8'h7C, 32'h80000000, 32'd33,       4'h8, 1, 2, 0, 1, 0, 32'd0,        32'h40000000, 32'd0,        0});
    vecs.push_back('{8'h7E, 32'hF0F0F0F0, 32'hFF00FF00, 4'h9, 1, 2, 0, 1, 0, 32'd0,        32'hF000F000, 32'd0,        0});
    vecs.push_back('{8'h80, 32'hF0F0F0F0, 32'hFF00FF00, 4'hA, 1, 2, 0, 1, 0, 32'd0,        32'hFFF0FFF0, 32'd0,        0});
    vecs.push_back('{8'h82, 32'hF0F0F0F0, 32'hFF00FF00, 4'hB, 1, 2, 0, 1, 0, 32'd0,        32'h0FF00FF0, 32'd0,        0});
    vecs.push_back('{8'h00, 32'd9,        32'd9,        4'h0, 0, 0, 0, 0, 0, 32'd0,        32'd0,        32'd0,        0});
    vecs.push_back('{8'h61, 32'd9,        32'd9,        4'h0, 0, 0, 0, 0, 0, 32'd0,        32'd0,        32'd0,        0});

    rst        = 1'b1;
    op_code    = 8'h00;
    exec_start = 1'b0;
    operand_a  = 32'd0;
    operand_b  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset result_lo", result_lo, 32'd0);
    chk("reset result_hi", result_hi, 32'd0);
    chk("reset div_zero", 32'(div_zero), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(i);

    // Back-to-back starts: done stays high, each result appears in turn.
    @(negedge clk);
    op_code = 8'h60; operand_a = 32'd100; operand_b = 32'd23; exec_start = 1'b1;
    @(negedge clk);
    chk("b2b first done", 32'(done), 32'd1);
    chk("b2b first lo", result_lo, 32'd123);
    op_code = 8'h68; operand_a = 32'hFFFFFFFF; operand_b = 32'hFFFFFFFF;
    @(negedge clk);
    chk("b2b second done", 32'(done), 32'd1);
    chk("b2b second lo", result_lo, 32'd1);
    chk("b2b second hi", result_hi, 32'd0);
    op_code = 8'h6C; operand_a = 32'd1; operand_b = 32'd0;
    @(negedge clk);
    chk("b2b third done", 32'(done), 32'd1);
    chk("b2b third lo", result_lo, 32'd0);
    chk("b2b third dz", 32'(div_zero), 32'd1);
    exec_start = 1'b0;
    @(negedge clk);
    chk("b2b end done", 32'(done), 32'd0);
    chk("b2b dz hold", 32'(div_zero), 32'd1);

    // Load a nonzero result, then reset coincides with a start.
    op_code = 8'h60; operand_a = 32'd7; operand_b = 32'd5; exec_start = 1'b1;
    @(negedge clk);
    chk("pre-reset lo", result_lo, 32'd12);
    operand_a = 32'd1; operand_b = 32'd1; rst = 1'b1;
    @(negedge clk);
    chk("rst+start done", 32'(done), 32'd0);
    chk("rst+start lo", result_lo, 32'd0);
    chk("rst+start hi", result_hi, 32'd0);
    chk("rst+start dz", 32'(div_zero), 32'd0);
    rst = 1'b0; exec_start = 1'b0;
    @(negedge clk);
    chk("post-reset done", 32'(done), 32'd0);
    chk("post-reset lo", result_lo, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
